io_wait_controller: RTL and testbench

- Sequences the core's multi-cycle I/O instructions: the switch-input instruction (wait for an operator press/release on `ent`, then latch `switch`) and the delay instruction (count down a programmed number of cycles).
- Drives a stall/advance handshake that the PC-update logic uses to hold the PC, then increments it once when the operation completes.
- Replaces ad-hoc stall flags in the PC update with a single debounced, abortable FSM.

---
 rtl/io_wait_pkg.sv | 18 +
 rtl/button_debouncer.sv | 45 ++++
 rtl/io_wait_controller.sv | 104 ++++++++++
 tb/tb_io_wait_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/io_wait_pkg.sv
// Shared types and default sizing for the I/O wait sequencer and its helpers.
// Imported by io_wait_controller and button_debouncer.
package io_wait_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_DEBOUNCE = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PRESS = 3'd2,
    REL   = 3'd3,
    DELAY = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus level debouncer for an asynchronous board key.
// Idles released (1); the output follows only after DEBOUNCE steady differing samples.
module button_debouncer
  import io_wait_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_db
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          key_meta;
  logic          key_sync;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      key_db   <= 1'b1;
      cnt      <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      if (key_sync != key_db) begin
        if (cnt == CW'(DEBOUNCE - 1)) begin
          key_db <= key_sync;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // any sample agreeing with the current level restarts the run
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/io_wait_controller.sv
// Multi-cycle I/O instruction sequencer: switch input on ent press/release and
// programmable delay, with a stall/advance handshake toward the PC-update logic.
module io_wait_controller
  import io_wait_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_req,
  input  logic              dly_req,
  input  logic [CNT_W-1:0]  dly_count,
  input  logic              ent,
  input  logic [DATA_W-1:0] switch,
  output logic              stall,
  output logic              advance,
  output logic [DATA_W-1:0] r_switch,
  output logic              busy
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   dly_cnt;
  logic [CNT_W-1:0]   dly_cnt_nxt;
  logic               capture;
  logic               ent_db;

  button_debouncer #(
    .DEBOUNCE(DEBOUNCE)
  ) u_db (
    .clk   (clk),
    .reset (reset),
    .key   (ent),
    .key_db(ent_db)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dly_cnt  <= '0;
      r_switch <= '0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_cnt_nxt;
      if (capture) r_switch <= switch;
    end
  end

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    capture     = 1'b0;
    advance     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_req) begin
          state_nxt = ARM;
        end else if (dly_req) begin
          state_nxt   = DELAY;
          dly_cnt_nxt = dly_count;
        end
      end
      // a press still held from the previous instruction must be released first
      ARM: begin
        if (!in_req)     state_nxt = IDLE;
        else if (ent_db) state_nxt = PRESS;
      end
      PRESS: begin
        if (!in_req)      state_nxt = IDLE;
        else if (!ent_db) state_nxt = REL;
      end
      REL: begin
        if (!in_req) begin
          state_nxt = IDLE;
        end else if (ent_db) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end
      end
      DELAY: begin
        if (!dly_req) begin
          state_nxt = IDLE;
        end else if (dly_cnt == '0) begin
          state_nxt = DONE;
        end else begin
          dly_cnt_nxt = dly_cnt - 1'b1;
        end
      end
      DONE: begin
        advance   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign stall = (busy && (state != DONE)) || ((state == IDLE) && (in_req || dly_req));

endmodule

// File: tb/tb_io_wait_controller.sv
// Directed bench for io_wait_controller: expected latency and r_switch per
// operation are queued when the request is driven and checked at the advance pulse.
module tb_io_wait_controller;
  import io_wait_pkg::*;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 32;
  localparam int BUDGET = 200;

  typedef struct {
    int               lat;
    logic [DATA_W-1:0] rsw;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_req;
  logic              dly_req;
  logic [CNT_W-1:0]  dly_count;
  logic              ent;
  logic [DATA_W-1:0] switch;
  logic              stall;
  logic              advance;
  logic [DATA_W-1:0] r_switch;
  logic              busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  io_wait_controller #(
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W),
    .DEBOUNCE(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .dly_req  (dly_req),
    .dly_count(dly_count),
    .ent      (ent),
    .switch   (switch),
    .stall    (stall),
    .advance  (advance),
    .r_switch (r_switch),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges until advance, checking stall on the way; then pops and
  // compares latency, r_switch, stall-in-advance-cycle and pulse width.
  task automatic wait_advance(input string tag);
    exp_t e;
    int   cyc;
    bit   seen;
    e    = sb.pop_front();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (advance === 1'b1) seen = 1'b1;
      else check({tag, "_stall_wait"}, 32'(stall), 32'd1);
    end
    check({tag, "_latency"}, cyc, e.lat);
    check({tag, "_stall_adv"}, 32'(stall), 32'd0);
    check({tag, "_r_switch"}, 32'(r_switch), 32'(e.rsw));
    in_req  = 1'b0;
    dly_req = 1'b0;
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(advance), 32'd0);
    check({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    reset     = 1'b1;
    in_req    = 1'b0;
    dly_req   = 1'b0;
    dly_count = '0;
    ent       = 1'b1;
    switch    = '0;

    // reset state
    cycles(3);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_advance", 32'(advance), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_r_switch", 32'(r_switch), 32'd0);
    reset = 1'b0;
    cycles(2);

    // delay of 3: four DELAY cycles, advance in the fifth
    dly_count = 32'd3;
    dly_req   = 1'b1;
    #1;
    check("d3_stall_accept", 32'(stall), 32'd1);
    check("d3_busy_accept", 32'(busy), 32'd0);
    sb.push_back('{lat: 5, rsw: 16'h0000});
    wait_advance("d3");

    // delay of 0
    dly_count = 32'd0;
    dly_req   = 1'b1;
    sb.push_back('{lat: 2, rsw: 16'h0000});
    wait_advance("d0");
    check("d0_no_underflow", dut.dly_cnt, 32'd0);

    // switch input with ent already held low
    ent = 1'b0;
    cycles(10);
    switch = 16'hA5C3;
    in_req = 1'b1;
    cycles(6);
    check("in_hold_arm", 32'(dut.state), 32'(ARM));
    check("in_hold_stall", 32'(stall), 32'd1);
    ent = 1'b1;
    cycles(8);
    check("in_press_wait", 32'(dut.state), 32'(PRESS));
    ent = 1'b0;
    cycles(10);
    check("in_rel_wait", 32'(dut.state), 32'(REL));
    check("in_no_early_capture", 32'(r_switch), 32'h0000);
    ent = 1'b1;
    sb.push_back('{lat: 7, rsw: 16'hA5C3});
    wait_advance("in1");

    // glitch shorter than the debounce window while in PRESS
    switch = 16'h1234;
    in_req = 1'b1;
    cycles(3);
    check("gl_press", 32'(dut.state), 32'(PRESS));
    ent = 1'b0;
    cycles(2);
    ent = 1'b1;
    cycles(8);
    check("gl_still_press", 32'(dut.state), 32'(PRESS));
    check("gl_stall", 32'(stall), 32'd1);
    check("gl_r_switch", 32'(r_switch), 32'hA5C3);
    ent = 1'b0;
    cycles(8);
    ent = 1'b1;
    sb.push_back('{lat: 7, rsw: 16'h1234});
    wait_advance("in2");

    // both requests: input wins; dropping in_req in PRESS aborts, then delay runs
    switch    = 16'hFFFF;
    dly_count = 32'd1;
    in_req    = 1'b1;
    dly_req   = 1'b1;
    cycles(1);
    check("both_arm", 32'(dut.state), 32'(ARM));
    cycles(1);
    check("both_press", 32'(dut.state), 32'(PRESS));
    in_req = 1'b0;
    cycles(1);
    check("abort_idle", 32'(dut.state), 32'(IDLE));
    check("abort_no_adv", 32'(advance), 32'd0);
    check("abort_r_switch", 32'(r_switch), 32'h1234);
    sb.push_back('{lat: 3, rsw: 16'h1234});
    wait_advance("after_abort");

    // reset with 20 delay cycles remaining
    dly_count = 32'd30;
    dly_req   = 1'b1;
    cycles(11);
    check("mid_count", dut.dly_cnt, 32'd20);
    reset   = 1'b1;
    dly_req = 1'b0;
    cycles(1);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_r_switch", 32'(r_switch), 32'd0);
    reset = 1'b0;
    cycles(1);
    dly_count = 32'd2;
    dly_req   = 1'b1;
    sb.push_back('{lat: 4, rsw: 16'h0000});
    wait_advance("d2");

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
